// File: rtl/gbox_ser_gen2_if.sv
// rtl/gbox_ser_gen2_if.sv - parallel word handshake into the gearbox serializer
interface gbox_ser_gen2_if #(
    parameter int PAR_DWID = 10
);
    logic [PAR_DWID-1:0] data_in;
    logic                data_oe;
    logic                data_valid;
    logic                data_ready;

    modport master (output data_in, data_oe, data_valid, input data_ready);
    modport slave  (input data_in, data_oe, data_valid, output data_ready);
endinterface

// File: rtl/gbox_ser_gen2.sv
// rtl/gbox_ser_gen2.sv - FIFO-fed gearbox serializer with runtime rate and bit order
module gbox_ser_gen2 #(
    parameter int PAR_DWID        = 10,
    parameter int FIFO_DEPTH      = 4,
    parameter int START_THRESHOLD = 2
) (
    input  logic                          fast_clk,
    input  logic                          tx_reset_n,
    gbox_ser_gen2_if.slave                word_if,
    input  logic                          cfg_enable,
    input  logic [4:0]                    rate_sel,
    input  logic                          cfg_lsb_first,
    input  logic                          err_clr,
    output logic                          ser_out,
    output logic                          ser_oe,
    output logic                          word_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun_err,
    output logic                          overflow_err,
    output logic                          cfg_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [4:0]    MAX_RATE = 5'(PAR_DWID);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] THR_LVL  = LW'(START_THRESHOLD);

    typedef enum logic [1:0] {IDLE, PREFILL, RUN} state_t;
    state_t state;

    logic [PAR_DWID:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [PAR_DWID-1:0] sh;
    logic                lsb_q;
    logic [4:0]          cnt;

    logic                push, pop, full, empty, rate_ok, load_pt;
    logic [LW-1:0]       level_nxt;
    logic [PAR_DWID-1:0] head, aligned;

    always_comb begin
        full      = (fifo_level == FULL_LVL);
        empty     = (fifo_level == '0);
        push      = word_if.data_valid && word_if.data_ready;
        rate_ok   = (rate_sel >= 5'd3) && (rate_sel <= MAX_RATE);
        load_pt   = cfg_enable && ((state == PREFILL && fifo_level >= THR_LVL) ||
                                   (state == RUN && cnt == '0 && !empty));
        pop       = load_pt && rate_ok;
        level_nxt = fifo_level;
        if (push && !pop)
            level_nxt = fifo_level + LW'(1);
        else if (pop && !push)
            level_nxt = fifo_level - LW'(1);
        head      = mem[rd_ptr][PAR_DWID-1:0];
        // MSB-first words are left-justified so every rate shifts out of the top bit
        aligned   = head << (MAX_RATE - rate_sel);
    end

    always_ff @(posedge fast_clk) begin
        if (!tx_reset_n) begin
            state              <= IDLE;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            fifo_level         <= '0;
            word_if.data_ready <= 1'b0;
            sh                 <= '0;
            lsb_q              <= 1'b0;
            cnt                <= '0;
            ser_out            <= 1'b0;
            ser_oe             <= 1'b0;
            word_start         <= 1'b0;
            underrun_err       <= 1'b0;
            overflow_err       <= 1'b0;
            cfg_err            <= 1'b0;
        end else begin
            fifo_level         <= level_nxt;
            word_if.data_ready <= (level_nxt != FULL_LVL);
            if (push) begin
                mem[wr_ptr] <= {word_if.data_oe, word_if.data_in};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            underrun_err <= (underrun_err && !err_clr) ||
                            (state == RUN && cnt == '0 && cfg_enable && empty);
            overflow_err <= (overflow_err && !err_clr) || (word_if.data_valid && full);
            cfg_err      <= (cfg_err && !err_clr) || (load_pt && !rate_ok);
            word_start   <= 1'b0;

            if (pop) begin
                state      <= RUN;
                cnt        <= rate_sel - 5'd1;
                lsb_q      <= cfg_lsb_first;
                ser_oe     <= mem[rd_ptr][PAR_DWID];
                word_start <= 1'b1;
                if (cfg_lsb_first) begin
                    ser_out <= head[0];
                    sh      <= head >> 1;
                end else begin
                    ser_out <= aligned[PAR_DWID-1];
                    sh      <= aligned << 1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        ser_out <= 1'b0;
                        ser_oe  <= 1'b0;
                        if (cfg_enable)
                            state <= PREFILL;
                    end
                    PREFILL: begin
                        ser_out <= 1'b0;
                        ser_oe  <= 1'b0;
                        if (!cfg_enable)
                            state <= IDLE;
                    end
                    RUN: begin
                        if (cnt != '0) begin
                            cnt     <= cnt - 5'd1;
                            ser_out <= lsb_q ? sh[0] : sh[PAR_DWID-1];
                            sh      <= lsb_q ? (sh >> 1) : (sh << 1);
                        end else begin
                            // word boundary without a load: stop, underrun or bad rate
                            ser_out <= 1'b0;
                            ser_oe  <= 1'b0;
                            state   <= cfg_enable ? PREFILL : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gbox_ser_gen2.sv
// tb/tb_gbox_ser_gen2.sv - directed vector bench for gbox_ser_gen2
module tb_gbox_ser_gen2;
    logic       fast_clk = 1'b0;
    logic       tx_reset_n, cfg_enable, cfg_lsb_first, err_clr;
    logic [4:0] rate_sel;
    logic       ser_out, ser_oe, word_start, underrun_err, overflow_err, cfg_err;
    logic [2:0] fifo_level;

    always #5 fast_clk = ~fast_clk;

    gbox_ser_gen2_if #(.PAR_DWID(10)) word_if ();

    gbox_ser_gen2 #(.PAR_DWID(10), .FIFO_DEPTH(4), .START_THRESHOLD(2)) dut (
        .fast_clk      (fast_clk),
        .tx_reset_n    (tx_reset_n),
        .word_if       (word_if),
        .cfg_enable    (cfg_enable),
        .rate_sel      (rate_sel),
        .cfg_lsb_first (cfg_lsb_first),
        .err_clr       (err_clr),
        .ser_out       (ser_out),
        .ser_oe        (ser_oe),
        .word_start    (word_start),
        .fifo_level    (fifo_level),
        .underrun_err  (underrun_err),
        .overflow_err  (overflow_err),
        .cfg_err       (cfg_err)
    );

    typedef struct {
        logic [9:0]  data;
        logic        oe;
        logic [4:0]  rate;
        logic        lsb;
        logic [15:0] bits;
    } vec_t;

    vec_t       tbl [8];
    logic [9:0] w [6];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic step();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_start(input string name, input int budget);
        int i;
        i = 0;
        while (word_start !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        chk({name, " start"}, 32'(word_start), 32'd1);
    endtask

    // current sample must hold the first bit; nrate/nlsb are applied right after it
    task automatic collect_word(input string name, input logic [15:0] bits, input int len,
                                input logic oe, input int drop_at,
                                input logic [4:0] nrate, input logic nlsb);
        logic [15:0] got, ws;
        logic        oe_ok;
        got   = '0;
        ws    = '0;
        oe_ok = 1'b1;
        for (int b = 0; b < len; b++) begin
            if (b > 0) step();
            got = {got[14:0], ser_out};
            ws  = {ws[14:0], word_start};
            if (ser_oe !== oe) oe_ok = 1'b0;
            if (b == 0) begin
                rate_sel      = nrate;
                cfg_lsb_first = nlsb;
            end
            if (b == drop_at) cfg_enable = 1'b0;
        end
        chk({name, " bits"}, 32'(got), 32'(bits));
        chk({name, " word_start"}, 32'(ws), 32'(16'(1) << (len - 1)));
        chk({name, " oe"}, 32'(oe_ok), 32'd1);
    endtask

    task automatic push_word(input logic [9:0] d, input logic oe);
        word_if.data_in    = d;
        word_if.data_oe    = oe;
        word_if.data_valid = 1'b1;
        step();
        word_if.data_valid = 1'b0;
    endtask

    task automatic run_group(input int first, input int n);
        int    j, nx;
        string nm;
        cfg_enable = 1'b0;
        step();
        step();
        for (int i = 0; i < n; i++) push_word(tbl[first + i].data, tbl[first + i].oe);
        rate_sel      = tbl[first].rate;
        cfg_lsb_first = tbl[first].lsb;
        cfg_enable    = 1'b1;
        wait_start($sformatf("grp%0d", first), 8);
        for (int k = 0; k < n; k++) begin
            j  = first + k;
            nx = (k < n - 1) ? j + 1 : j;
            if (k > 0) step();
            nm = $sformatf("vec%0d", j);
            collect_word(nm, tbl[j].bits, int'(tbl[j].rate), tbl[j].oe, -1,
                         tbl[nx].rate, tbl[nx].lsb);
        end
        step();
        chk($sformatf("grp%0d underrun", first), 32'(underrun_err), 32'd1);
        chk($sformatf("grp%0d idle out", first), 32'({ser_oe, ser_out}), 32'd0);
        chk($sformatf("grp%0d level", first), 32'(fifo_level), 32'd0);
        step();
        step();
        chk($sformatf("grp%0d quiet", first), 32'({ser_oe, ser_out, word_start}), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk($sformatf("grp%0d err_clr", first), 32'(underrun_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic ws_seen, out_seen;
        tbl[0] = '{10'h2B5, 1'b1, 5'd10, 1'b0, 16'b1010110101};
        tbl[1] = '{10'h0F0, 1'b0, 5'd10, 1'b0, 16'b0011110000};
        tbl[2] = '{10'h013, 1'b1, 5'd5,  1'b1, 16'b11001};
        tbl[3] = '{10'h00A, 1'b1, 5'd5,  1'b1, 16'b01010};
        tbl[4] = '{10'h155, 1'b1, 5'd8,  1'b0, 16'b01010101};
        tbl[5] = '{10'h07B, 1'b1, 5'd7,  1'b1, 16'b1101111};
        tbl[6] = '{10'h2C6, 1'b0, 5'd3,  1'b0, 16'b110};
        tbl[7] = '{10'h3FF, 1'b1, 5'd4,  1'b1, 16'b1111};
        w[0] = 10'h3A5; w[1] = 10'h05A; w[2] = 10'h2CC;
        w[3] = 10'h1E3; w[4] = 10'h111; w[5] = 10'h222;

        tx_reset_n = 1'b0; cfg_enable = 1'b0; rate_sel = 5'd10; cfg_lsb_first = 1'b0;
        err_clr = 1'b0; word_if.data_valid = 1'b0; word_if.data_in = '0; word_if.data_oe = 1'b0;
        step(); step(); step();
        chk("reset outs", 32'({ser_out, ser_oe, word_start}), 32'd0);
        chk("reset level", 32'(fifo_level), 32'd0);
        chk("reset flags", 32'({underrun_err, overflow_err, cfg_err}), 32'd0);
        chk("reset ready", 32'(word_if.data_ready), 32'd0);
        tx_reset_n = 1'b1;
        step();
        chk("ready after reset", 32'(word_if.data_ready), 32'd1);

        run_group(0, 2);
        run_group(2, 2);
        run_group(4, 4);

        // overflow: six offered words, FIFO of four, serializer stopped
        cfg_enable = 1'b0;
        step(); step();
        for (int i = 0; i < 6; i++) begin
            word_if.data_in = w[i]; word_if.data_oe = 1'b1; word_if.data_valid = 1'b1;
            step();
            if (i == 3)
                chk("full state", 32'({word_if.data_ready, overflow_err, fifo_level}), 32'({1'b0, 1'b0, 3'd4}));
        end
        word_if.data_valid = 1'b0;
        chk("overflow flag", 32'(overflow_err), 32'd1);
        chk("overflow level", 32'(fifo_level), 32'd4);
        chk("overflow ready", 32'(word_if.data_ready), 32'd0);

        // graceful stop after bit 3, then resume with the stored words
        rate_sel = 5'd10; cfg_lsb_first = 1'b0; cfg_enable = 1'b1;
        wait_start("w0", 8);
        collect_word("w0", 16'b1110100101, 10, 1'b1, 2, 5'd10, 1'b0);
        step();
        chk("stop out", 32'({ser_oe, ser_out, word_start}), 32'd0);
        chk("stop level", 32'(fifo_level), 32'd3);
        step(); step(); step();
        chk("idle level", 32'({ser_oe, fifo_level}), 32'd3);
        cfg_enable = 1'b1;
        wait_start("w1", 8);
        collect_word("w1", 16'b0001011010, 10, 1'b1, 5, 5'd10, 1'b0);
        step();
        chk("w1 stop level", 32'({ser_oe, fifo_level}), 32'd2);

        // illegal rate at the load point
        rate_sel = 5'd2; cfg_enable = 1'b1;
        ws_seen = 1'b0; out_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            ws_seen  = ws_seen | word_start;
            out_seen = out_seen | ser_oe | ser_out;
        end
        chk("cfg_err", 32'(cfg_err), 32'd1);
        chk("cfg_err no pop", 32'(fifo_level), 32'd2);
        chk("cfg_err silent", 32'({ws_seen, out_seen}), 32'd0);
        rate_sel = 5'd10;
        wait_start("w2", 4);
        collect_word("w2", 16'b1011001100, 10, 1'b1, -1, 5'd7, 1'b0);
        step();
        collect_word("w3 rate7", 16'b1100011, 7, 1'b1, -1, 5'd7, 1'b0);
        step();
        chk("w3 underrun", 32'({underrun_err, ser_oe}), 32'b10);
        chk("all flags", 32'({underrun_err, overflow_err, cfg_err}), 32'b111);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("flags cleared", 32'({underrun_err, overflow_err, cfg_err}), 32'd0);

        // reset in the middle of a word
        rate_sel = 5'd10;
        push_word(10'h3FF, 1'b1);
        push_word(10'h3FF, 1'b1);
        wait_start("rstw", 6);
        step(); step();
        chk("pre-reset oe", 32'({ser_oe, ser_out}), 32'b11);
        tx_reset_n = 1'b0;
        step();
        chk("mid reset outs", 32'({ser_out, ser_oe, word_start}), 32'd0);
        chk("mid reset level", 32'(fifo_level), 32'd0);
        tx_reset_n = 1'b1; cfg_enable = 1'b0;
        step();
        chk("post reset ready", 32'(word_if.data_ready), 32'd1);
        step();
        chk("post reset quiet", 32'({ser_out, ser_oe, word_start}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
